// File: rtl/gate_sweep_pkg.sv
// ---------------------------------------------------------------------------
// gate_sweep_pkg
// Shared definitions for the gate truth-table sweep controller:
//   sweep_state_t  - controller state encoding (2 bits)
//   NVEC           - vector count for the default 3-input gate
//   CNT_W          - settle counter width (SETTLE range 0..15)
//   EXPECT_*       - reference truth tables for common 3-input gates,
//                    bit i = expected output for input vector i
// ---------------------------------------------------------------------------
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_W,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int unsigned N_IN_DEFAULT = 3;
    localparam int unsigned NVEC         = 2 ** N_IN_DEFAULT;
    localparam int unsigned CNT_W        = 4;

    localparam logic [NVEC-1:0] EXPECT_AND3 = 8'b1000_0000;
    localparam logic [NVEC-1:0] EXPECT_OR3  = 8'b1111_1110;
    localparam logic [NVEC-1:0] EXPECT_XOR3 = 8'b1001_0110;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl_if
// Control/status bundle of the sweep controller.
//   start, abort                 - commands from the host (master)
//   busy, done, pass             - sweep status
//   result                       - captured truth table (NVEC bits)
//   mismatch_cnt                 - number of mismatching vectors (N_IN+1 bits)
//   fail_valid, first_fail       - lowest mismatching vector index
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface gate_sweep_ctrl_if #(
    parameter int unsigned N_IN = 3
) ();
    localparam int unsigned NV = 2 ** N_IN;

    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            pass;
    logic [NV-1:0]   result;
    logic [N_IN:0]   mismatch_cnt;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, abort,
        input  busy, done, pass, result, mismatch_cnt, fail_valid, first_fail
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, result, mismatch_cnt, fail_valid, first_fail
    );
endinterface

// File: rtl/sweep_settle_timer.sv
// ---------------------------------------------------------------------------
// sweep_settle_timer
// Loadable down-counter timing the settle interval after a vector change.
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load LOAD into the counter
//   clear     - force the counter to zero (has priority over load)
//   expire    - high in the last settle cycle (counter == 1)
// The counter stops at zero; with LOAD=0 expire never asserts.
// ---------------------------------------------------------------------------
module sweep_settle_timer
    import gate_sweep_pkg::*;
#(
    parameter logic [CNT_W-1:0] LOAD = 4'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expire
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == CNT_W'(1));
endmodule

// File: rtl/gate_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl
// Truth-table sequencer for a small combinational gate. Drives every input
// vector in ascending order, waits SETTLE cycles, samples the gate output and
// compares it against EXPECT.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - control/status interface (slave side)
//   dut_out   - output of the gate under test
//   dut_in    - registered input vector to the gate (MSB = first gate input)
// ---------------------------------------------------------------------------
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned        N_IN   = 3,
    parameter int unsigned        SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXPECT = EXPECT_AND3
) (
    input  logic             clk,
    input  logic             rst,
    gate_sweep_ctrl_if.slave bus,
    input  logic             dut_out,
    output logic [N_IN-1:0]  dut_in
);
    localparam int unsigned NV = 2 ** N_IN;
    // With no settle time the sweep goes straight from one sample to the next.
    localparam sweep_state_t RUN_ENTRY = (SETTLE == 0) ? SAMPLE : SETTLE_W;

    sweep_state_t    state;
    logic [N_IN-1:0] vec;
    logic            busy_r, done_r, pass_r, fv_r;
    logic [NV-1:0]   result_r;
    logic [N_IN:0]   mm_r;
    logic [N_IN-1:0] ff_r;

    logic            miss, last_vec, abort_now, accept;
    logic            tmr_load, tmr_clear, tmr_expire;
    logic [N_IN:0]   mm_next;

    always_comb begin
        miss      = dut_out ^ EXPECT[vec];
        mm_next   = mm_r + {{N_IN{1'b0}}, miss};
        last_vec  = (vec == '1);
        abort_now = bus.abort && ((state == SETTLE_W) || (state == SAMPLE));
        accept    = (state == IDLE) && bus.start && !bus.abort;
        tmr_load  = accept || ((state == SAMPLE) && !bus.abort && !last_vec);
        tmr_clear = abort_now;
    end

    sweep_settle_timer #(
        .LOAD (CNT_W'(SETTLE))
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .clear  (tmr_clear),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vec      <= '0;
            dut_in   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            result_r <= '0;
            mm_r     <= '0;
            fv_r     <= 1'b0;
            ff_r     <= '0;
        end else begin
            done_r <= 1'b0;
            if (abort_now) begin
                // Partial result/mismatch fields are kept for inspection.
                state  <= IDLE;
                vec    <= '0;
                dut_in <= '0;
                busy_r <= 1'b0;
                pass_r <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            state    <= RUN_ENTRY;
                            vec      <= '0;
                            dut_in   <= '0;
                            busy_r   <= 1'b1;
                            pass_r   <= 1'b0;
                            result_r <= '0;
                            mm_r     <= '0;
                            fv_r     <= 1'b0;
                            ff_r     <= '0;
                        end
                    end
                    SETTLE_W: begin
                        if (tmr_expire) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        result_r[vec] <= dut_out;
                        if (miss) begin
                            mm_r <= mm_next;
                            if (!fv_r) begin
                                fv_r <= 1'b1;
                                ff_r <= vec;
                            end
                        end
                        if (last_vec) begin
                            // pass uses the count including this final sample.
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= (mm_next == '0);
                            dut_in <= '0;
                            vec    <= '0;
                        end else begin
                            state  <= RUN_ENTRY;
                            vec    <= vec + 1'b1;
                            dut_in <= vec + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.pass         = pass_r;
    assign bus.result       = result_r;
    assign bus.mismatch_cnt = mm_r;
    assign bus.fail_valid   = fv_r;
    assign bus.first_fail   = ff_r;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_ctrl
// Three controllers share clk/rst: A (SETTLE=1, gate selectable AND3/OR3),
// B (SETTLE=0, AND3) and C (SETTLE=3, AND3). Expected sweep outcomes come
// from a small truth-table model and are queued when a sweep is launched.
// ---------------------------------------------------------------------------
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] result;
        logic [3:0] mm;
        logic       fv;
        logic [2:0] ff;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int   set_v[3];
    logic gate_or = 1'b0;
    logic start_v[3];
    logic abort_v[3];

    logic [2:0] din_a, din_b, din_c;
    logic       out_a, out_b, out_c;

    logic       done_w[3], busy_w[3], pass_w[3], fv_w[3];
    logic [7:0] res_w[3];
    logic [3:0] mm_w[3];
    logic [2:0] ff_w[3], din_w[3];

    gate_sweep_ctrl_if #(.N_IN(3)) if_a ();
    gate_sweep_ctrl_if #(.N_IN(3)) if_b ();
    gate_sweep_ctrl_if #(.N_IN(3)) if_c ();

    assign out_a = gate_or ? (|din_a) : (&din_a);
    assign out_b = &din_b;
    assign out_c = &din_c;

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(1), .EXPECT(EXPECT_AND3)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave), .dut_out(out_a), .dut_in(din_a));
    gate_sweep_ctrl #(.N_IN(3), .SETTLE(0), .EXPECT(EXPECT_AND3)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave), .dut_out(out_b), .dut_in(din_b));
    gate_sweep_ctrl #(.N_IN(3), .SETTLE(3), .EXPECT(EXPECT_AND3)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave), .dut_out(out_c), .dut_in(din_c));

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_a.abort = abort_v[0];
    assign if_b.abort = abort_v[1];
    assign if_c.abort = abort_v[2];

    assign done_w[0] = if_a.done;  assign done_w[1] = if_b.done;  assign done_w[2] = if_c.done;
    assign busy_w[0] = if_a.busy;  assign busy_w[1] = if_b.busy;  assign busy_w[2] = if_c.busy;
    assign pass_w[0] = if_a.pass;  assign pass_w[1] = if_b.pass;  assign pass_w[2] = if_c.pass;
    assign fv_w[0]   = if_a.fail_valid;
    assign fv_w[1]   = if_b.fail_valid;
    assign fv_w[2]   = if_c.fail_valid;
    assign res_w[0]  = if_a.result; assign res_w[1] = if_b.result; assign res_w[2] = if_c.result;
    assign mm_w[0]   = if_a.mismatch_cnt;
    assign mm_w[1]   = if_b.mismatch_cnt;
    assign mm_w[2]   = if_c.mismatch_cnt;
    assign ff_w[0]   = if_a.first_fail;
    assign ff_w[1]   = if_b.first_fail;
    assign ff_w[2]   = if_c.first_fail;
    assign din_w[0]  = din_a;      assign din_w[1] = din_b;      assign din_w[2] = din_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit use_or, input int s);
        exp_t       e;
        logic [7:0] ex;
        logic       g;
        ex       = EXPECT_AND3;
        e.result = '0;
        e.mm     = '0;
        e.fv     = 1'b0;
        e.ff     = '0;
        for (int v = 0; v < 8; v++) begin
            g = use_or ? (v != 0) : (v == 7);
            e.result[v] = g;
            if (g != ex[v]) begin
                e.mm = e.mm + 4'd1;
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.ff = 3'(v);
                end
            end
        end
        e.pass = (e.mm == 4'd0);
        e.lat  = 8 * (s + 1) + 1;
        return e;
    endfunction

    task automatic check_outputs_zero(input int k, input string tag);
        chk({tag, "_busy"},   32'(busy_w[k]), 0);
        chk({tag, "_done"},   32'(done_w[k]), 0);
        chk({tag, "_pass"},   32'(pass_w[k]), 0);
        chk({tag, "_result"}, 32'(res_w[k]),  0);
        chk({tag, "_mm"},     32'(mm_w[k]),   0);
        chk({tag, "_fv"},     32'(fv_w[k]),   0);
        chk({tag, "_ff"},     32'(ff_w[k]),   0);
        chk({tag, "_din"},    32'(din_w[k]),  0);
    endtask

    // Full sweep on controller k; optional extra start pulses in cycle 3
    // and in the done cycle, both of which must be ignored.
    task automatic sweep(input int k, input bit re_mid, input bit re_done);
        int   c;
        exp_t e;
        sb.push_back(model((k == 0) && gate_or, set_v[k]));
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        c = 1;
        while (done_w[k] !== 1'b1 && c < 200) begin
            chk("busy_run", 32'(busy_w[k]), 1);
            chk("dut_in_step", 32'(din_w[k]), 32'((c - 1) / (set_v[k] + 1)));
            if (re_mid && c == 3) start_v[k] = 1'b1;
            @(posedge clk);
            #1;
            start_v[k] = 1'b0;
            c++;
        end
        e = sb.pop_front();
        chk("done_seen",   32'(done_w[k]), 1);
        chk("latency",     32'(c), 32'(e.lat));
        chk("busy_done",   32'(busy_w[k]), 0);
        chk("dut_in_done", 32'(din_w[k]), 0);
        chk("result",      32'(res_w[k]), 32'(e.result));
        chk("mismatch",    32'(mm_w[k]),  32'(e.mm));
        chk("fail_valid",  32'(fv_w[k]),  32'(e.fv));
        chk("first_fail",  32'(ff_w[k]),  32'(e.ff));
        chk("pass",        32'(pass_w[k]), 32'(e.pass));
        if (re_done) start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        chk("done_single", 32'(done_w[k]), 0);
        chk("idle_busy",   32'(busy_w[k]), 0);
        chk("hold_result", 32'(res_w[k]), 32'(e.result));
        chk("hold_pass",   32'(pass_w[k]), 32'(e.pass));
        if (re_done) begin
            @(posedge clk);
            #1;
            chk("no_restart", 32'(busy_w[k]), 0);
        end
    endtask

    initial begin
        int c;
        set_v[0] = 1; set_v[1] = 0; set_v[2] = 3;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
        end

        // Reset state
        #12;
        for (int i = 0; i < 3; i++) check_outputs_zero(i, "reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero(0, "post_reset");

        // 1: correct AND3, SETTLE=1
        gate_or = 1'b0;
        sweep(0, 1'b0, 1'b0);

        // 2: OR3 attached while expecting AND3
        gate_or = 1'b1;
        sweep(0, 1'b0, 1'b0);

        // 3: SETTLE=0 and SETTLE=3
        sweep(1, 1'b0, 1'b0);
        sweep(2, 1'b0, 1'b0);

        // 4: start re-pulsed in cycle 3 and in the done cycle
        gate_or = 1'b0;
        sweep(0, 1'b1, 1'b1);

        // 5: abort in cycle 6 (OR3 so the partial fields are non-zero)
        gate_or = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        c = 1;
        while (c < 6) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("abort_busy_before", 32'(busy_w[0]), 1);
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        chk("abort_busy",   32'(busy_w[0]), 0);
        chk("abort_din",    32'(din_w[0]),  0);
        chk("abort_done",   32'(done_w[0]), 0);
        chk("abort_pass",   32'(pass_w[0]), 0);
        chk("abort_result", 32'(res_w[0]),  32'h02);
        chk("abort_mm",     32'(mm_w[0]),   1);
        chk("abort_fv",     32'(fv_w[0]),   1);
        chk("abort_ff",     32'(ff_w[0]),   1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done_w[0] | busy_w[0]), 0);
        end
        // abort and start together in IDLE: no sweep
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("abort_wins", 32'(busy_w[0]), 0);
        gate_or = 1'b0;
        sweep(0, 1'b0, 1'b0);

        // 6: asynchronous reset mid-SETTLE_W at vec=4
        gate_or = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        c = 1;
        while (c < 9) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("pre_rst_din", 32'(din_w[0]), 4);
        chk("pre_rst_mm",  32'(mm_w[0]),  3);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero(0, "async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("rst_idle", 32'({busy_w[0], done_w[0], din_w[0]}), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
